// File: rtl/adder_share_arb.sv
// ============================================================================
// adder_share_arb : round-robin shared 32-bit prefix adder with saved carries
// Revision 1.0
// ============================================================================
`default_nettype none

module adder_share_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  input  logic [NREQ-1:0]       req_chain,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  if (WIDTH != 32) begin : g_bad_width
    $error("adder_share_arb: WIDTH must be 32");
  end
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("adder_share_arb: NREQ must be 2..4");
  end

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  carry;
  logic             slot_free;
  logic             grant;
  logic [IDW-1:0]   gid;
  logic [IDW-1:0]   sel;
  int               arb_idx;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  assign rsp_valid = (state == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant     = 1'b0;
    gid       = '0;
    sel       = '0;
    arb_idx   = 0;
    req_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NREQ;
      sel     = IDW'(arb_idx);
      if (!grant && req_valid[sel]) begin
        grant = 1'b1;
        gid   = sel;
      end
    end
    if (!slot_free) grant = 1'b0;
    if (grant) req_ready[gid] = 1'b1;
  end

  logic [WIDTH-1:0] a_sel, bx, p0, gg, pp, sum;
  logic             cin, cout, ovf;

  assign a_sel = a_arr[gid];
  assign bx    = req_sub[gid] ? ~b_arr[gid] : b_arr[gid];
  assign cin   = req_chain[gid] ? carry[gid] : req_sub[gid];

  // Kogge-Stone prefix; carry-in folded into bit 0 generate so gg[i] is carry out of bit i
  always_comb begin
    p0    = a_sel ^ bx;
    pp    = p0;
    gg    = a_sel & bx;
    gg[0] = gg[0] | (p0[0] & cin);
    for (int l = 0; l < LEVELS; l++) begin
      gg = gg | (pp & (gg << (1 << l)));
      pp = pp & ((pp << (1 << l)) | ((WIDTH'(1) << (1 << l)) - WIDTH'(1)));
    end
    sum  = p0 ^ {gg[WIDTH-2:0], cin};
    cout = gg[WIDTH-1];
    ovf  = (a_sel[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (rsp_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
      rr_ptr   <= IDW'(NREQ - 1);
      carry    <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        rsp_sum    <= sum;
        rsp_cout   <= cout;
        rsp_ovf    <= ovf;
        rsp_id     <= gid;
        rr_ptr     <= gid;
        carry[gid] <= cout;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arb.sv
// ============================================================================
// tb_adder_share_arb : scoreboard bench for the shared adder arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_adder_share_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = $clog2(NREQ);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        chain;
    logic [31:0] s;
    logic        c;
    logic        o;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    s;
    logic           c;
    logic           o;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ-1:0]       req_chain;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;

  adder_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  op_t  opq [NREQ][$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_rsp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic chain,
                        input logic [31:0] s, input logic c, input logic o);
    op_t op;
    op.a = a; op.b = b; op.sub = sub; op.chain = chain;
    op.s = s; op.c = c; op.o = o;
    opq[id].push_back(op);
  endtask

  task automatic apply_drives();
    for (int i = 0; i < NREQ; i++) begin
      if (opq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_a[i*WIDTH +: WIDTH] = opq[i][0].a;
        req_b[i*WIDTH +: WIDTH] = opq[i][0].b;
        req_sub[i]            = opq[i][0].sub;
        req_chain[i]          = opq[i][0].chain;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while ((opq[0].size() > 0 || opq[1].size() > 0 || sb.size() > 0) && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_within_budget", 64'(cyc < budget), 64'd1);
  endtask

  // Driver plus reference arbiter: predicts req_ready and queues the expected result
  int             m_ptr;
  logic           m_full;
  initial begin
    logic [NREQ-1:0] exp_rdy;
    logic            g_found;
    int              g_id;
    int              idx;
    exp_t            e;
    m_ptr  = NREQ - 1;
    m_full = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_ptr  = NREQ - 1;
        m_full = 1'b0;
      end else begin
        exp_rdy = '0;
        g_found = 1'b0;
        g_id    = 0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (!g_found && req_valid[idx]) begin
            g_found = 1'b1;
            g_id    = idx;
          end
        end
        if (m_full && !rsp_ready) g_found = 1'b0;
        if (g_found) exp_rdy[g_id] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g_found) begin
          e.id = IDW'(g_id);
          e.s  = opq[g_id][0].s;
          e.c  = opq[g_id][0].c;
          e.o  = opq[g_id][0].o;
          sb.push_back(e);
          void'(opq[g_id].pop_front());
          m_ptr = g_id;
        end
        m_full = g_found || (m_full && !rsp_ready);
        @(posedge clk);
        #1;
        apply_drives();
      end
    end
  end

  // Monitor: a held result is compared every cycle, popped when consumed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb[0];
          chk("rsp_id",   64'(rsp_id),   64'(e.id));
          chk("rsp_sum",  64'(rsp_sum),  64'(e.s));
          chk("rsp_cout", 64'(rsp_cout), 64'(e.c));
          chk("rsp_ovf",  64'(rsp_ovf),  64'(e.o));
          if (rsp_ready) begin
            void'(sb.pop_front());
            n_rsp++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n0;
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_chain = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);
    chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("reset_rsp_cout",  64'(rsp_cout),  64'd0);
    chk("reset_rsp_ovf",   64'(rsp_ovf),   64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Carry-out of the low word feeds the chained high word
    add_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    add_op(0, 32'h0,         32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    drain(20, cyc);

    add_op(1, 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    add_op(1, 32'h0,         32'h1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    add_op(1, 32'h5,         32'h2, 1'b1, 1'b1, 32'h2,         1'b1, 1'b0);
    drain(20, cyc);

    // Interleaved chains from both requesters, one result per cycle
    add_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    add_op(0, 32'h1,         32'h2,         1'b0, 1'b1, 32'h4,         1'b0, 1'b0);
    add_op(0, 32'h7FFF_FFFF, 32'h0,         1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0);
    add_op(0, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    add_op(1, 32'h3,         32'h5,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add_op(1, 32'hA,         32'h0,         1'b1, 1'b1, 32'h9,         1'b1, 1'b0);
    add_op(1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    add_op(1, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0);
    n0 = n_rsp;
    drain(40, cyc);
    chk("b2b_result_count", 64'(n_rsp - n0), 64'd8);
    chk("b2b_cycles_le_11", 64'(cyc <= 11), 64'd1);

    // Backpressure: result held stable while consumer stalls
    rsp_ready = 1'b0;
    add_op(0, 32'h1,   32'h1,  1'b0, 1'b0, 32'h2,  1'b0, 1'b0);
    add_op(0, 32'h2,   32'h2,  1'b0, 1'b0, 32'h4,  1'b0, 1'b0);
    add_op(1, 32'h10,  32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);
    add_op(1, 32'h100, 32'h1,  1'b1, 1'b0, 32'hFF, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_one_held", 64'(sb.size()), 64'd1);
    rsp_ready = 1'b1;
    drain(40, cyc);

    // Reset while full, with chained words still pending
    rsp_ready = 1'b0;
    add_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    add_op(0, 32'h0,         32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    add_op(1, 32'h0,         32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(rsp_valid), 64'd0);
    chk("async_reset_sum",   64'(rsp_sum),   64'd0);
    chk("async_reset_cout",  64'(rsp_cout),  64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    reset_n   = 1'b1;
    drain(20, cyc);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
